// File: rtl/instr_fetch_16.sv
// rtl/instr_fetch_16.sv - instruction fetch sequencer; jump decode enabled by FETCH_JUMP_EN
module instr_fetch_16 #(
  parameter logic [3:0] JMP_OPCODE = 4'b1100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc,
  output logic        pc_enable,
  output logic        pc_load,
  output logic [15:0] pc_target,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready
);

`ifdef FETCH_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  // REDIRECT is unreachable; pc_load and pc_target never leave their reset values
  localparam bit JUMP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    HOLD     = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        pc_enable_nxt;
  logic        pc_load_nxt;
  logic [15:0] pc_target_nxt;
  logic [15:0] imem_addr_nxt;
  logic        imem_req_nxt;
  logic [15:0] ir_nxt;
  logic        ir_valid_nxt;

  logic        jump_hit;
  logic [15:0] pc_after_edge;

  // An acknowledged word with the jump opcode redirects instead of reaching the decoder
  assign jump_hit = JUMP_EN && (imem_data[15:12] == JMP_OPCODE);

  // The counter steps on the same edge that pc_enable is high, so the next
  // request must already use the stepped value; 16-bit add wraps FFFF->0000
  assign pc_after_edge = pc + {15'd0, pc_enable};

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered outputs; reset abandons any outstanding request and drops ir_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_enable <= 1'b0;
      pc_load   <= 1'b0;
      pc_target <= 16'h0000;
      imem_addr <= 16'h0000;
      imem_req  <= 1'b0;
      ir        <= 16'h0000;
      ir_valid  <= 1'b0;
    end else begin
      pc_enable <= pc_enable_nxt;
      pc_load   <= pc_load_nxt;
      pc_target <= pc_target_nxt;
      imem_addr <= imem_addr_nxt;
      imem_req  <= imem_req_nxt;
      ir        <= ir_nxt;
      ir_valid  <= ir_valid_nxt;
    end
  end

  // Next-state and next-output decode; strobes default low so each is a single-cycle pulse
  always_comb begin
    state_nxt     = state;
    pc_enable_nxt = 1'b0;
    pc_load_nxt   = 1'b0;
    pc_target_nxt = pc_target;
    imem_addr_nxt = imem_addr;
    imem_req_nxt  = imem_req;
    ir_nxt        = ir;
    ir_valid_nxt  = ir_valid;

    case (state)
      IDLE: begin
        imem_addr_nxt = pc;
        imem_req_nxt  = 1'b1;
        state_nxt     = REQ;
      end

      REQ: begin
        if (imem_ack) begin
          imem_req_nxt = 1'b0;
          if (jump_hit) begin
            // Target stays within the page of the fetching address
            pc_target_nxt = {imem_addr[15:12], imem_data[11:0]};
            pc_load_nxt   = 1'b1;
            state_nxt     = REDIRECT;
          end else begin
            ir_nxt        = imem_data;
            ir_valid_nxt  = 1'b1;
            pc_enable_nxt = 1'b1;
            state_nxt     = HOLD;
          end
        end
      end

      HOLD: begin
        if (ir_valid && ir_ready) begin
          ir_valid_nxt  = 1'b0;
          imem_addr_nxt = pc_after_edge;
          imem_req_nxt  = 1'b1;
          state_nxt     = REQ;
        end
      end

      REDIRECT: begin
        // The counter takes pc_target on this edge, so fetch from it directly
        imem_addr_nxt = pc_target;
        imem_req_nxt  = 1'b1;
        state_nxt     = REQ;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Counter strobes are mutually exclusive
  a_strobes_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(pc_enable && pc_load));

  // A request is never outstanding while the decoder still holds a word
  a_req_vs_valid: assert property (@(posedge clk) disable iff (reset)
    imem_req |-> !ir_valid);

endmodule
